// File: rtl/sram_pkg.sv
// Shared types and defaults for the 128K x 16 SRAM model.
// Holds width defaults, depth, the command enum and the strobe decoder.
package sram_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 17;
    localparam int unsigned SRAM_DEPTH = 1 << SRAM_ADDR_W;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_WRITE,
        CMD_READ
    } cmd_e;

    // Active-low strobes; a write wins over a read when both are asserted.
    function automatic cmd_e decode_cmd(
        input logic ce,
        input logic we,
        input logic oe
    );
        cmd_e cmd;
        cmd = CMD_IDLE;
        unique case (1'b1)
            (!ce && !we):       cmd = CMD_WRITE;
            (!ce && we && !oe): cmd = CMD_READ;
            default:            cmd = CMD_IDLE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port block RAM with registered read port and no reset.
// Ports: clk, en (access), we (write), addr, din, dout (registered).
module sram_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Zero contents come from the configuration image, not from reset.
    logic [DATA_W-1:0] mem [(1 << ADDR_W)] = '{default: '0};

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram.sv
// Synchronous SRAM model with active-low CE/OE/WE strobes.
// Ports: clk, reset (sync, high), CE/OE/WE, input_data, address, stackData.
module sram
    import sram_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CE,
    input  logic              OE,
    input  logic              WE,
    input  logic [DATA_W-1:0] input_data,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] stackData
);

    cmd_e              cmd;
    logic              arr_en;
    logic              arr_we;
    logic [DATA_W-1:0] arr_dout;
    logic              rd_q;

    assign cmd    = decode_cmd(CE, WE, OE);
    assign arr_en = !reset && (cmd != CMD_IDLE);
    assign arr_we = !reset && (cmd == CMD_WRITE);

    sram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk (clk),
        .en  (arr_en),
        .we  (arr_we),
        .addr(address),
        .din (input_data),
        .dout(arr_dout)
    );

    // The RAM output register only updates on reads, so it can hold stale
    // data; this flag marks whether the last edge actually was a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= (cmd == CMD_READ);
        end
    end

    assign stackData = rd_q ? arr_dout : '0;

endmodule

// File: tb/tb_sram.sv
// Directed self-checking bench for the sram model.
// Drives strobes between edges and samples 1 ns after each rising edge.
module tb_sram;

    logic        clk;
    logic        reset;
    logic        CE;
    logic        OE;
    logic        WE;
    logic [15:0] input_data;
    logic [16:0] address;
    logic [15:0] stackData;

    int tests_run;
    int tests_failed;

    sram dut (
        .clk       (clk),
        .reset     (reset),
        .CE        (CE),
        .OE        (OE),
        .WE        (WE),
        .input_data(input_data),
        .address   (address),
        .stackData (stackData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(
        input logic        r,
        input logic        ce,
        input logic        we,
        input logic        oe,
        input logic [16:0] a,
        input logic [15:0] d
    );
        reset      = r;
        CE         = ce;
        WE         = we;
        OE         = oe;
        address    = a;
        input_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 17'h0, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_c1 got=%h exp=0000", stackData);
        end
        step(1, 1, 1, 1, 17'h0, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_c2 got=%h exp=0000", stackData);
        end
        step(0, 1, 1, 1, 17'h0, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_idle got=%h exp=0000", stackData);
        end
    endtask

    task automatic test_write_read();
        step(0, 0, 0, 1, 17'h0, 16'h0001);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wr_out got=%h exp=0000", stackData);
        end
        step(0, 0, 1, 0, 17'h0, 16'h0);
        tests_run++;
        if (stackData !== 16'h0001) begin
            tests_failed++;
            $display("FAIL rd_a0 got=%h exp=0001", stackData);
        end
        step(0, 1, 1, 1, 17'h0, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rd_release got=%h exp=0000", stackData);
        end
    endtask

    task automatic test_priority();
        step(0, 0, 0, 0, 17'd5, 16'hBEEF);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL prio_out got=%h exp=0000", stackData);
        end
        step(0, 0, 1, 0, 17'd5, 16'h0);
        tests_run++;
        if (stackData !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL prio_rd got=%h exp=beef", stackData);
        end
    endtask

    task automatic test_deselect();
        step(0, 1, 0, 1, 17'd7, 16'hFFFF);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL desel_wr got=%h exp=0000", stackData);
        end
        step(0, 1, 1, 0, 17'd5, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL desel_rd got=%h exp=0000", stackData);
        end
        step(0, 0, 1, 1, 17'd5, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL noop_oe got=%h exp=0000", stackData);
        end
        step(0, 0, 1, 0, 17'd7, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL desel_a7 got=%h exp=0000", stackData);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 1, 17'd9, 16'h1234);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstwr_out got=%h exp=0000", stackData);
        end
        step(0, 0, 1, 0, 17'd5, 16'h0);
        tests_run++;
        if (stackData !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL pre_rst_rd got=%h exp=beef", stackData);
        end
        step(1, 0, 1, 0, 17'd5, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstrd_out got=%h exp=0000", stackData);
        end
        step(0, 0, 1, 0, 17'd9, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_a9 got=%h exp=0000", stackData);
        end
        step(0, 0, 1, 0, 17'd0, 16'h0);
        tests_run++;
        if (stackData !== 16'h0001) begin
            tests_failed++;
            $display("FAIL rst_keep_a0 got=%h exp=0001", stackData);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 0, 1, 17'd3, 16'h0033);
        step(0, 0, 1, 0, 17'd3, 16'h0);
        tests_run++;
        if (stackData !== 16'h0033) begin
            tests_failed++;
            $display("FAIL b2b_a3 got=%h exp=0033", stackData);
        end
        step(0, 0, 0, 1, 17'd4, 16'hC0DE);
        step(0, 0, 1, 0, 17'd3, 16'h0);
        tests_run++;
        if (stackData !== 16'h0033) begin
            tests_failed++;
            $display("FAIL b2b_a3b got=%h exp=0033", stackData);
        end
        step(0, 0, 1, 0, 17'd4, 16'h0);
        tests_run++;
        if (stackData !== 16'hC0DE) begin
            tests_failed++;
            $display("FAIL b2b_a4 got=%h exp=c0de", stackData);
        end
    endtask

    task automatic test_boundary();
        step(0, 0, 0, 1, 17'h1FFFF, 16'hA5A5);
        step(0, 0, 0, 1, 17'h00000, 16'h5A5A);
        step(0, 0, 1, 0, 17'h1FFFF, 16'h0);
        tests_run++;
        if (stackData !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL bnd_top got=%h exp=a5a5", stackData);
        end
        step(0, 0, 1, 0, 17'h00000, 16'h0);
        tests_run++;
        if (stackData !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL bnd_bot got=%h exp=5a5a", stackData);
        end
        step(0, 0, 1, 0, 17'h0FFFF, 16'h0);
        tests_run++;
        if (stackData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL bnd_alias got=%h exp=0000", stackData);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        CE           = 1'b1;
        OE           = 1'b1;
        WE           = 1'b1;
        address      = '0;
        input_data   = '0;
        #2;
        test_reset();
        test_write_read();
        test_priority();
        test_deselect();
        test_reset_mid();
        test_back_to_back();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
